// File: rtl/controlador_expansao_pkg.sv
// Shared definitions for the expansion controller: FSM encoding and
// default parameter values used by every file of the block.
package controlador_expansao_pkg;

  localparam int NUM_NA_DEF         = 8;
  localparam int CRITERIO_WIDTH_DEF = 5;
  localparam int IDX_WIDTH_DEF      = 3;
  localparam int ITER_WIDTH_DEF     = 8;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    VARRER    = 3'd1,
    DESPACHAR = 3'd2,
    AGUARDAR  = 3'd3,
    FIM       = 3'd4
  } estado_t;

endpackage

// File: rtl/controlador_expansao_if.sv
// Expander handshake bundle: request (valid/idx), acceptance (ready),
// completion (done) and the one-hot clear of the dispatched node.
interface controlador_expansao_if
  import controlador_expansao_pkg::*;
#(
  parameter int NUM_NA    = NUM_NA_DEF,
  parameter int IDX_WIDTH = IDX_WIDTH_DEF
) ();

  logic                 exp_valid;
  logic [IDX_WIDTH-1:0] exp_idx;
  logic                 exp_ready;
  logic                 exp_done;
  logic [NUM_NA-1:0]    desativar;

  modport master (
    output exp_valid, exp_idx, desativar,
    input  exp_ready, exp_done
  );

  modport slave (
    input  exp_valid, exp_idx, desativar,
    output exp_ready, exp_done
  );

endinterface

// File: rtl/controlador_expansao_varredor_minimo.sv
// Linear scan over the node table: one node per cycle while en is high,
// tracking the active node with the smallest criterion (lowest index on
// ties). The *_next outputs already include the node under the counter,
// so on the last scan cycle they hold the final answer.
module varredor_minimo
  import controlador_expansao_pkg::*;
#(
  parameter int NUM_NA         = NUM_NA_DEF,
  parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_DEF,
  parameter int IDX_WIDTH      = IDX_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [NUM_NA-1:0]                na_ativo,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio,
  output logic                             ultimo,
  output logic                             achou,
  output logic [IDX_WIDTH-1:0]             melhor_idx
);

  logic [CRITERIO_WIDTH-1:0] criterio_arr [NUM_NA];
  logic [IDX_WIDTH-1:0]      contador_reg;
  logic                      achou_reg;
  logic [IDX_WIDTH-1:0]      melhor_idx_reg;
  logic [CRITERIO_WIDTH-1:0] melhor_crit_reg;

  logic                      ativo_atual;
  logic [CRITERIO_WIDTH-1:0] crit_atual;
  logic                      toma;
  logic                      achou_next;
  logic [IDX_WIDTH-1:0]      melhor_idx_next;
  logic [CRITERIO_WIDTH-1:0] melhor_crit_next;

  // Unpack the flat criterion bus into one entry per node.
  generate
    for (genvar gi = 0; gi < NUM_NA; gi++) begin : g_unpack
      assign criterio_arr[gi] = na_criterio[CRITERIO_WIDTH*gi +: CRITERIO_WIDTH];
    end
  endgenerate

  // Compare the node under the counter against the best seen so far.
  always_comb begin
    ativo_atual      = na_ativo[contador_reg];
    crit_atual       = criterio_arr[contador_reg];
    toma             = ativo_atual && (!achou_reg || (crit_atual < melhor_crit_reg));
    achou_next       = achou_reg | ativo_atual;
    melhor_idx_next  = toma ? contador_reg : melhor_idx_reg;
    melhor_crit_next = toma ? crit_atual : melhor_crit_reg;
  end

  assign ultimo     = en && (contador_reg == IDX_WIDTH'(NUM_NA - 1));
  assign achou      = achou_next;
  assign melhor_idx = melhor_idx_next;

  // Step the scan while enabled; any idle cycle rearms it from node 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_reg    <= '0;
      achou_reg       <= 1'b0;
      melhor_idx_reg  <= '0;
      melhor_crit_reg <= '0;
    end else if (!en) begin
      contador_reg    <= '0;
      achou_reg       <= 1'b0;
      melhor_idx_reg  <= '0;
      melhor_crit_reg <= '0;
    end else begin
      contador_reg    <= contador_reg + 1'b1;
      achou_reg       <= achou_next;
      melhor_idx_reg  <= melhor_idx_next;
      melhor_crit_reg <= melhor_crit_next;
    end
  end

endmodule

// File: rtl/controlador_expansao.sv
// Search-loop controller: scans the node table for the cheapest active
// node, dispatches it to the expander, waits for the table update and
// repeats until the target is the best node, nothing is left, or the
// iteration budget runs out. IDX_WIDTH must cover NUM_NA nodes.
module controlador_expansao
  import controlador_expansao_pkg::*;
#(
  parameter int NUM_NA         = NUM_NA_DEF,
  parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_DEF,
  parameter int IDX_WIDTH      = IDX_WIDTH_DEF,
  parameter int ITER_WIDTH     = ITER_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_in,
  input  logic                             abort_in,
  input  logic [IDX_WIDTH-1:0]             destino_idx_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  controlador_expansao_if.master           exp,
  output logic                             busy_out,
  output logic                             done_out,
  output logic                             sucesso_out,
  output logic                             falha_out,
  output logic [ITER_WIDTH-1:0]            iter_out
);

  localparam logic [ITER_WIDTH-1:0] ITER_MAX = '1;

  estado_t                 estado_reg;
  logic [IDX_WIDTH-1:0]    destino_reg;
  logic [ITER_WIDTH-1:0]   iter_reg;
  logic                    exp_valid_reg;
  logic [IDX_WIDTH-1:0]    exp_idx_reg;
  logic [NUM_NA-1:0]       desativar_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    sucesso_reg;
  logic                    falha_reg;

  logic                    ultimo;
  logic                    achou;
  logic [IDX_WIDTH-1:0]    melhor_idx;
  logic [ITER_WIDTH-1:0]   iter_inc;
  logic [NUM_NA-1:0]       mascara;

  varredor_minimo #(
    .NUM_NA         (NUM_NA),
    .CRITERIO_WIDTH (CRITERIO_WIDTH),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_varredor (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (estado_reg == VARRER),
    .na_ativo    (na_ativo_in),
    .na_criterio (na_criterio_in),
    .ultimo      (ultimo),
    .achou       (achou),
    .melhor_idx  (melhor_idx)
  );

  // Next iteration count and the one-hot clear for the dispatched node.
  always_comb begin
    iter_inc = iter_reg + 1'b1;
    mascara  = '0;
    mascara[exp_idx_reg] = 1'b1;
  end

  // Main FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg    <= OCIOSO;
      destino_reg   <= '0;
      iter_reg      <= '0;
      exp_valid_reg <= 1'b0;
      exp_idx_reg   <= '0;
      desativar_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sucesso_reg   <= 1'b0;
      falha_reg     <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      desativar_reg <= '0;
      if (abort_in && (estado_reg != OCIOSO)) begin
        estado_reg    <= OCIOSO;
        exp_valid_reg <= 1'b0;
        busy_reg      <= 1'b0;
        falha_reg     <= 1'b1;
      end else begin
        case (estado_reg)
          OCIOSO: begin
            if (start_in) begin
              estado_reg  <= VARRER;
              destino_reg <= destino_idx_in;
              iter_reg    <= '0;
              sucesso_reg <= 1'b0;
              falha_reg   <= 1'b0;
              busy_reg    <= 1'b1;
            end
          end
          VARRER: begin
            if (ultimo) begin
              if (!achou) begin
                estado_reg <= FIM;
                falha_reg  <= 1'b1;
                done_reg   <= 1'b1;
              end else if (melhor_idx == destino_reg) begin
                estado_reg  <= FIM;
                sucesso_reg <= 1'b1;
                done_reg    <= 1'b1;
              end else begin
                estado_reg    <= DESPACHAR;
                exp_valid_reg <= 1'b1;
                exp_idx_reg   <= melhor_idx;
              end
            end
          end
          DESPACHAR: begin
            if (exp.exp_ready) begin
              estado_reg    <= AGUARDAR;
              exp_valid_reg <= 1'b0;
              desativar_reg <= mascara;
            end
          end
          AGUARDAR: begin
            if (exp.exp_done) begin
              iter_reg <= iter_inc;
              if (iter_inc == ITER_MAX) begin
                estado_reg <= FIM;
                falha_reg  <= 1'b1;
                done_reg   <= 1'b1;
              end else begin
                estado_reg <= VARRER;
              end
            end
          end
          FIM: begin
            estado_reg <= OCIOSO;
            busy_reg   <= 1'b0;
          end
          default: begin
            estado_reg <= OCIOSO;
            busy_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign exp.exp_valid = exp_valid_reg;
  assign exp.exp_idx   = exp_idx_reg;
  assign exp.desativar = desativar_reg;
  assign busy_out      = busy_reg;
  assign done_out      = done_reg;
  assign sucesso_out   = sucesso_reg;
  assign falha_out     = falha_reg;
  assign iter_out      = iter_reg;

endmodule

// File: tb/tb_controlador_expansao.sv
// Directed bench for controlador_expansao: one default instance (a) and
// one with a 2-bit iteration counter (b) for the iteration-limit case.
module tb_controlador_expansao;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic [2:0]  destino;
  logic [7:0]  ativo;
  logic [39:0] crit;

  logic        busy_a, done_a, sucesso_a, falha_a;
  logic [7:0]  iter_a;
  logic        busy_b, done_b, sucesso_b, falha_b;
  logic [1:0]  iter_b;

  int n_cmp = 0;
  int n_err = 0;

  controlador_expansao_if #(.NUM_NA(8), .IDX_WIDTH(3)) ifa ();
  controlador_expansao_if #(.NUM_NA(8), .IDX_WIDTH(3)) ifb ();

  controlador_expansao dut_a (
    .clk(clk), .rst_n(rst_n), .start_in(start_a), .abort_in(abort_a),
    .destino_idx_in(destino), .na_ativo_in(ativo), .na_criterio_in(crit),
    .exp(ifa.master), .busy_out(busy_a), .done_out(done_a),
    .sucesso_out(sucesso_a), .falha_out(falha_a), .iter_out(iter_a)
  );

  controlador_expansao #(.ITER_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_in(start_b), .abort_in(abort_b),
    .destino_idx_in(destino), .na_ativo_in(ativo), .na_criterio_in(crit),
    .exp(ifb.master), .busy_out(busy_b), .done_out(done_b),
    .sucesso_out(sucesso_b), .falha_out(falha_b), .iter_out(iter_b)
  );

  always #5 clk = ~clk;

  task automatic conferir(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_cmp++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic set_crit(input int i, input logic [4:0] v);
    crit[5*i +: 5] = v;
  endtask

  // Start pulse for one cycle; returns at the first negedge after acceptance.
  task automatic pulso_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  int vistos, disp, dones, falha_fim, iter_fim, primeiro_des;

  initial begin
    rst_n = 1'b0; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    destino = '0; ativo = '0; crit = '0;
    ifa.exp_ready = 0; ifa.exp_done = 0; ifb.exp_ready = 0; ifb.exp_done = 0;

    // Reset values
    repeat (2) @(negedge clk);
    conferir("rst_valid", ifa.exp_valid, 0);
    conferir("rst_idx", ifa.exp_idx, 0);
    conferir("rst_desativar", ifa.desativar, 0);
    conferir("rst_busy", busy_a, 0);
    conferir("rst_done", done_a, 0);
    conferir("rst_sucesso", sucesso_a, 0);
    conferir("rst_falha", falha_a, 0);
    conferir("rst_iter", iter_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // No active node: failure after NUM_NA+1 cycles, no dispatch
    ativo = 8'h00;
    pulso_start_a();
    vistos = int'(ifa.exp_valid);
    repeat (7) begin @(negedge clk); vistos += int'(ifa.exp_valid); end
    conferir("vazio_done_c8", done_a, 0);
    @(negedge clk);
    conferir("vazio_done_c9", done_a, 1);
    conferir("vazio_falha", falha_a, 1);
    conferir("vazio_sucesso", sucesso_a, 0);
    conferir("vazio_iter", iter_a, 0);
    @(negedge clk);
    conferir("vazio_done_pulse", done_a, 0);
    conferir("vazio_busy_end", busy_a, 0);
    conferir("vazio_no_valid", vistos, 0);

    // Min search with a tie at crit 3 (nodes 2,5) and an inactive crit-0 node
    set_crit(1, 5'd7); set_crit(2, 5'd3); set_crit(5, 5'd3);
    ativo = 8'h26; destino = 3'd6;
    pulso_start_a();
    repeat (7) @(negedge clk);
    conferir("desp_valid_c8", ifa.exp_valid, 0);
    @(negedge clk);
    conferir("desp_valid_c9", ifa.exp_valid, 1);
    conferir("desp_idx", ifa.exp_idx, 2);
    ifa.exp_done = 1'b1; start_a = 1'b1;
    @(negedge clk);
    ifa.exp_done = 1'b0; start_a = 1'b0;
    conferir("desp_done_ignored_iter", iter_a, 0);
    for (int k = 0; k < 5; k++) begin
      conferir("stall_valid", ifa.exp_valid, 1);
      conferir("stall_idx", ifa.exp_idx, 2);
      conferir("stall_desativar", ifa.desativar, 0);
      if (k < 4) @(negedge clk);
    end
    ifa.exp_ready = 1'b1;
    @(negedge clk);
    ifa.exp_ready = 1'b0;
    conferir("hs_desativar", ifa.desativar, 8'h04);
    conferir("hs_valid_low", ifa.exp_valid, 0);
    @(negedge clk);
    conferir("hs_desativar_pulse", ifa.desativar, 0);
    conferir("aguardar_busy", busy_a, 1);

    // start while busy is ignored: no new dispatch appears
    pulso_start_a();
    vistos = 0;
    repeat (10) begin @(negedge clk); vistos += int'(ifa.exp_valid); end
    conferir("busy_start_ignored", vistos, 0);

    // Expansion leaves only the target active -> success on rescan
    ativo = 8'h40;
    ifa.exp_done = 1'b1;
    @(negedge clk);
    ifa.exp_done = 1'b0;
    repeat (7) @(negedge clk);
    conferir("rescan_done_c8", done_a, 0);
    @(negedge clk);
    conferir("rescan_done_c9", done_a, 1);
    conferir("rescan_sucesso", sucesso_a, 1);
    conferir("rescan_falha", falha_a, 0);
    conferir("rescan_iter", iter_a, 1);
    @(negedge clk);

    // Target already best: success without dispatch, start clears iter
    ativo = 8'h10; set_crit(4, 5'd0); destino = 3'd4;
    pulso_start_a();
    conferir("alvo_iter_clr", iter_a, 0);
    conferir("alvo_sucesso_clr", sucesso_a, 0);
    vistos = int'(ifa.exp_valid);
    repeat (8) begin @(negedge clk); vistos += int'(ifa.exp_valid); end
    conferir("alvo_done", done_a, 1);
    conferir("alvo_sucesso", sucesso_a, 1);
    conferir("alvo_falha", falha_a, 0);
    conferir("alvo_no_valid", vistos, 0);
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    conferir("abort_idle_falha", falha_a, 0);
    conferir("abort_idle_sucesso", sucesso_a, 1);

    // Abort while dispatching
    ativo = 8'h26; destino = 3'd6;
    pulso_start_a();
    repeat (8) @(negedge clk);
    conferir("abort_pre_valid", ifa.exp_valid, 1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    conferir("abort_valid", ifa.exp_valid, 0);
    conferir("abort_falha", falha_a, 1);
    conferir("abort_busy", busy_a, 0);
    conferir("abort_done", done_a, 0);
    vistos = 0;
    repeat (3) begin @(negedge clk); vistos += int'(done_a); end
    conferir("abort_no_done", vistos, 0);

    // Asynchronous reset while waiting for the expander
    ifa.exp_ready = 1'b1;
    pulso_start_a();
    repeat (8) @(negedge clk);
    @(negedge clk);
    ifa.exp_ready = 1'b0;
    conferir("aguard_desativar", ifa.desativar, 8'h04);
    @(negedge clk);
    conferir("aguard_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    conferir("arst_busy", busy_a, 0);
    conferir("arst_idx", ifa.exp_idx, 0);
    conferir("arst_valid", ifa.exp_valid, 0);
    conferir("arst_falha", falha_a, 0);
    conferir("arst_iter", iter_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Iteration limit on the 2-bit instance: expander never clears node 2
    ativo = 8'h26; destino = 3'd6;
    ifb.exp_ready = 1'b1; ifb.exp_done = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    disp = 0; dones = 0; falha_fim = 0; iter_fim = 0; primeiro_des = 0;
    for (int c = 0; c < 120; c++) begin
      if (ifb.desativar != 0) begin
        if (disp == 0) primeiro_des = int'(ifb.desativar);
        disp++;
      end
      if (done_b) begin
        dones++;
        falha_fim = int'(falha_b);
        iter_fim  = int'(iter_b);
      end
      @(negedge clk);
    end
    conferir("iter_dispatches", disp, 3);
    conferir("iter_first_desativar", primeiro_des, 8'h04);
    conferir("iter_done_pulses", dones, 1);
    conferir("iter_falha_at_done", falha_fim, 1);
    conferir("iter_count_at_done", iter_fim, 3);
    conferir("iter_sucesso", sucesso_b, 0);
    conferir("iter_busy_end", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
